game_ctrl: RTL and testbench

Parametrised game-state controller for the VGA runner game, replacing the single-bit run/stop flag in the top level. Arms on a START press, enters play only during vertical blanking, stops on collision between the player sprite and any of N hazard channels, and supports pause/resume. Maintains frame-based score, high score and a speed level that feeds the scrolling layers (ground, hazards). Sits between the button/VGA signals and the sprite modules, all on CLK.

---
 rtl/game_pkg.sv | 16 +
 rtl/edge_sync.sv | 28 ++
 rtl/game_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the runner game: controller state codes and default widths
// that the scrolling layers also use.
package game_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StArmed = 3'd1,
      StRun   = 3'd2,
      StPause = 3'd3,
      StOver  = 3'd4
   } game_state_e;

   localparam int unsigned ScoreWDefault = 16;
   localparam int unsigned SpeedWDefault = 4;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle pulse on its
// synchronised rising edge.
module edge_sync (
   input  logic CLK,
   input  logic RESET,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: arms on START, plays from the next vertical blanking, ends on
// sprite/hazard collision, and keeps score, high score and speed level.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned N_HAZARD   = 2,
   parameter int unsigned SCORE_W    = ScoreWDefault,
   parameter int unsigned SPEED_W    = SpeedWDefault,
   parameter int unsigned SPEED_STEP = 100
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                start_btn,
   input  logic                pause_btn,
   input  logic                vs,
   input  logic                px_player,
   input  logic [N_HAZARD-1:0] px_hazard,
   output logic [2:0]          state,
   output logic                running,
   output logic [SCORE_W-1:0]  score,
   output logic [SCORE_W-1:0]  hi_score,
   output logic [SPEED_W-1:0]  speed,
   output logic [N_HAZARD-1:0] hit_mask
);

   localparam int unsigned StepW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
   localparam logic [StepW-1:0] StepLast = StepW'(SPEED_STEP - 1);

   logic start_rise, pause_rise, vs_rise, vs_sync;
   logic start_lvl_unused, pause_lvl_unused;

   edge_sync u_start_sync (
      .CLK     (CLK),
      .RESET   (RESET),
      .async_i (start_btn),
      .sync_o  (start_lvl_unused),
      .rise_o  (start_rise)
   );

   edge_sync u_pause_sync (
      .CLK     (CLK),
      .RESET   (RESET),
      .async_i (pause_btn),
      .sync_o  (pause_lvl_unused),
      .rise_o  (pause_rise)
   );

   edge_sync u_vs_sync (
      .CLK     (CLK),
      .RESET   (RESET),
      .async_i (vs),
      .sync_o  (vs_sync),
      .rise_o  (vs_rise)
   );

   game_state_e         state_q, state_d;
   logic                new_game_q, new_game_d;
   logic [SCORE_W-1:0]  score_q, score_d, hi_q, hi_d;
   logic [SPEED_W-1:0]  speed_q, speed_d;
   logic [StepW-1:0]    step_q, step_d;
   logic [N_HAZARD-1:0] hit_q, hit_d;
   logic                collide;

   // Pixel inputs are already in the CLK domain, so collision is taken raw.
   assign collide = px_player & (|px_hazard);

   always_comb begin
      state_d    = state_q;
      new_game_d = new_game_q;
      score_d    = score_q;
      hi_d       = hi_q;
      speed_d    = speed_q;
      step_d     = step_q;
      hit_d      = hit_q;

      unique case (state_q)
         StIdle: begin
            if (start_rise) begin
               state_d    = StArmed;
               new_game_d = 1'b1;
            end
         end
         StArmed: begin
            if (!vs_sync) begin
               state_d    = StRun;
               new_game_d = 1'b0;
               if (new_game_q) begin
                  score_d = '0;
                  hit_d   = '0;
                  step_d  = '0;
                  speed_d = SPEED_W'(1);
               end
            end
         end
         StRun: begin
            if (collide) begin
               state_d = StOver;
               hit_d   = px_hazard & {N_HAZARD{px_player}};
            end else if (pause_rise) begin
               state_d = StPause;
            end else if (vs_rise) begin
               if (score_q != '1) score_d = score_q + SCORE_W'(1);
               if (step_q == StepLast) begin
                  step_d = '0;
                  if (speed_q != '1) speed_d = speed_q + SPEED_W'(1);
               end else begin
                  step_d = step_q + StepW'(1);
               end
            end
         end
         StPause: begin
            if (pause_rise) begin
               state_d    = StArmed;
               new_game_d = 1'b0;
            end
         end
         StOver: begin
            // Score is frozen in OVER, so re-evaluating every cycle equals a one-shot update.
            if (score_q > hi_q) hi_d = score_q;
            if (start_rise) begin
               state_d    = StArmed;
               new_game_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= StIdle;
         new_game_q <= 1'b0;
         score_q    <= '0;
         hi_q       <= '0;
         speed_q    <= SPEED_W'(1);
         step_q     <= '0;
         hit_q      <= '0;
      end else begin
         state_q    <= state_d;
         new_game_q <= new_game_d;
         score_q    <= score_d;
         hi_q       <= hi_d;
         speed_q    <= speed_d;
         step_q     <= step_d;
         hit_q      <= hit_d;
      end
   end

   assign state    = state_q;
   assign running  = (state_q == StRun);
   assign score    = score_q;
   assign hi_score = hi_q;
   assign speed    = speed_q;
   assign hit_mask = hit_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a 16-bit-score instance and a 4-bit-score instance
// share all stimulus; expectations are queued with a due cycle and checked by a monitor.
module tb_game_ctrl;

   logic       CLK = 1'b0;
   logic       RESET, start_btn, pause_btn, vs, px_player;
   logic [1:0] px_hazard;

   logic [2:0]  st_a, st_b;
   logic        run_a, run_b;
   logic [15:0] sc_a, hi_a;
   logic [3:0]  sc_b, hi_b;
   logic [3:0]  sp_a, sp_b;
   logic [1:0]  hm_a, hm_b;

   game_ctrl #(.N_HAZARD(2), .SCORE_W(16), .SPEED_W(4), .SPEED_STEP(100)) u_dut_a (
      .CLK(CLK), .RESET(RESET), .start_btn(start_btn), .pause_btn(pause_btn), .vs(vs),
      .px_player(px_player), .px_hazard(px_hazard), .state(st_a), .running(run_a),
      .score(sc_a), .hi_score(hi_a), .speed(sp_a), .hit_mask(hm_a)
   );

   game_ctrl #(.N_HAZARD(2), .SCORE_W(4), .SPEED_W(4), .SPEED_STEP(100)) u_dut_b (
      .CLK(CLK), .RESET(RESET), .start_btn(start_btn), .pause_btn(pause_btn), .vs(vs),
      .px_player(px_player), .px_hazard(px_hazard), .state(st_b), .running(run_b),
      .score(sc_b), .hi_score(hi_b), .speed(sp_b), .hit_mask(hm_b)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      string name;
      int    due;
      int    st;
      int    sc;
      int    hi;
      int    sp;
      int    hm;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model, updated by hand alongside the stimulus.
   int m_st, m_sc, m_hi, m_sp, m_hm;

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic expect_now(input string name);
      exp_t e;
      e.name = name; e.due = cyc;
      e.st = m_st; e.sc = m_sc; e.hi = m_hi; e.sp = m_sp; e.hm = m_hm;
      sb.push_back(e);
   endtask

   always @(negedge CLK) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         if (e.due != cyc || int'(st_a) != e.st || run_a != (e.st == 2) || int'(sc_a) != e.sc
             || int'(hi_a) != e.hi || int'(sp_a) != e.sp || int'(hm_a) != e.hm) begin
            n_bad++;
            $display("FAIL %s [w16] got st=%0d run=%0b sc=%0d hi=%0d sp=%0d hm=%0d, want st=%0d sc=%0d hi=%0d sp=%0d hm=%0d",
                     e.name, st_a, run_a, sc_a, hi_a, sp_a, hm_a, e.st, e.sc, e.hi, e.sp, e.hm);
         end
         n_vec++;
         if (e.due != cyc || int'(st_b) != e.st || run_b != (e.st == 2)
             || int'(sc_b) != sat15(e.sc) || int'(hi_b) != sat15(e.hi) || int'(sp_b) != e.sp
             || int'(hm_b) != e.hm) begin
            n_bad++;
            $display("FAIL %s [w4] got st=%0d run=%0b sc=%0d hi=%0d sp=%0d hm=%0d, want st=%0d sc=%0d hi=%0d sp=%0d hm=%0d",
                     e.name, st_b, run_b, sc_b, hi_b, sp_b, hm_b, e.st, sat15(e.sc),
                     sat15(e.hi), e.sp, e.hm);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // One video frame: a single vs rising edge, ending in blanking.
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         vs = 1'b1; tick(4);
         vs = 1'b0; tick(4);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_sc = 0; m_hi = 0; m_sp = 1; m_hm = 0;
   endtask

   initial begin
      RESET = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; vs = 1'b1;
      px_player = 1'b0; px_hazard = 2'b00;
      model_reset();
      tick(3);
      RESET = 1'b0;
      expect_now("reset_values");
      tick(2);
      expect_now("idle_after_reset");

      // START during active video; ARMED waits for blanking.
      start_btn = 1'b1;
      tick(2); expect_now("start_in_sync");
      tick(1); m_st = 1; expect_now("armed");
      tick(2); start_btn = 1'b0;
      tick(48); expect_now("armed_wait_vs");
      vs = 1'b0;
      tick(2); expect_now("armed_vs_in_sync");
      tick(1); m_st = 2; expect_now("run_entry");

      frames(20);  m_sc = 20;  expect_now("score20_sat");
      frames(79);  m_sc = 99;  expect_now("score99_speed1");
      frames(1);   m_sc = 100; m_sp = 2; expect_now("score100_speed2");
      frames(150); m_sc = 250; m_sp = 3; expect_now("score250_speed3");

      px_player = 1'b1; px_hazard = 2'b10;
      tick(1); m_st = 4; m_hm = 2; expect_now("collide_over");
      px_player = 1'b0; px_hazard = 2'b00;
      tick(1); m_hi = 250; expect_now("hi_update");

      // Second game: already in blanking, so RUN follows ARMED immediately.
      start_btn = 1'b1;
      tick(3); m_st = 1; expect_now("armed_g2");
      tick(1); m_st = 2; m_sc = 0; m_hm = 0; m_sp = 1; expect_now("run_g2");
      start_btn = 1'b0;
      frames(40); m_sc = 40; expect_now("score40");

      pause_btn = 1'b1;
      tick(2); expect_now("pause_in_sync");
      tick(1); m_st = 3; expect_now("paused");
      pause_btn = 1'b0;
      px_player = 1'b1; px_hazard = 2'b11;
      tick(2); expect_now("pause_collide_ignored");
      px_player = 1'b0; px_hazard = 2'b00;
      frames(30); expect_now("pause_frozen");
      vs = 1'b1; tick(3);
      pause_btn = 1'b1;
      tick(3); m_st = 1; expect_now("resume_armed");
      tick(5); expect_now("armed_wait_blank");
      pause_btn = 1'b0; vs = 1'b0;
      tick(2); expect_now("armed_blank_in_sync");
      tick(1); m_st = 2; expect_now("resume_run");
      frames(5); m_sc = 45; expect_now("score45");

      // Collision and pause edge in the same cycle.
      pause_btn = 1'b1;
      tick(2); px_player = 1'b1; px_hazard = 2'b01;
      tick(1); m_st = 4; m_hm = 1; expect_now("collide_beats_pause");
      px_player = 1'b0; px_hazard = 2'b00; pause_btn = 1'b0;
      tick(1); expect_now("hi_kept");
      pause_btn = 1'b1;
      tick(4); expect_now("over_pause_ignored");
      pause_btn = 1'b0;

      start_btn = 1'b1;
      tick(3); m_st = 1; expect_now("armed_g3");
      tick(1); m_st = 2; m_sc = 0; m_hm = 0; expect_now("run_g3");
      start_btn = 1'b0;
      frames(3); m_sc = 3; expect_now("score3_g3");

      RESET = 1'b1;
      tick(1); model_reset(); expect_now("reset_mid_run");
      RESET = 1'b0;
      px_player = 1'b1; px_hazard = 2'b11;
      tick(2); expect_now("idle_collide_ignored");
      px_player = 1'b0; px_hazard = 2'b00;
      pause_btn = 1'b1;
      tick(4); expect_now("idle_pause_ignored");
      pause_btn = 1'b0;

      tick(3);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++; n_bad++;
         $display("FAIL %s never checked (due cycle %0d, now %0d)", e.name, e.due, cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
